bram_log_ctrl: RTL and testbench

- Parametrised write controller for the BRAM sample logger in the DSP path.
- Generates write strobe and write address into a DEPTH-word BRAM from a streaming sample source.
- Supports one-shot and circular capture, programmable decimation, software stop, and a done/status readout for the host.

---
 rtl/bram_log_ctrl.sv | 116 +++++++++++
 tb/tb_bram_log_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_log_ctrl.sv
// bram_log_ctrl
//   Write controller for the BRAM sample logger in the DSP path. Produces the
//   write strobe and write address for a DEPTH-word BRAM from a streaming
//   sample source, with one-shot or circular capture, programmable
//   decimation, software stop and a done/status readout for the host.
//
// Parameters
//   ADDR_W  BRAM address width
//   DEPTH   number of words logged (2 <= DEPTH <= 2**ADDR_W)
//   DEC_W   width of the decimation setting
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   run       start/restart capture, honoured in IDLE and DONE
//   stop      abort/finish capture, honoured in WRITE
//   mode      0 = one-shot, 1 = circular (latched when run is accepted)
//   decim     write one of every decim+1 valid samples (latched on run)
//   in_valid  source sample valid this cycle
//   write     BRAM write enable
//   addr      BRAM write address
//   busy      high while capturing
//   done      high once capture has finished
//   wrapped   circular capture has overwritten at least once
//   count     words written since start, saturating at DEPTH
module bram_log_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int DEC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stop,
    input  logic              mode,
    input  logic [DEC_W-1:0]  decim,
    input  logic              in_valid,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t             state;
    logic               mode_l;
    logic [DEC_W-1:0]   decim_l;
    logic [DEC_W-1:0]   dc;

    // Strobe is decoded from registered state so a valid sample is written
    // in the same cycle it arrives.
    assign write = (state == WRITE) && in_valid && (dc == '0);
    assign busy  = (state == WRITE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            dc      <= '0;
            mode_l  <= 1'b0;
            decim_l <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (run) begin
                        state   <= WRITE;
                        addr    <= '0;
                        count   <= '0;
                        wrapped <= 1'b0;
                        dc      <= '0;
                        mode_l  <= mode;
                        decim_l <= decim;
                    end
                end
                WRITE: begin
                    if (in_valid)
                        dc <= (dc == decim_l) ? '0 : dc + DEC_W'(1);
                    if (stop)
                        state <= DONE;
                    // A write coinciding with stop still lands and updates
                    // addr/count; a one-shot final write also goes to DONE,
                    // so both events together give the same result.
                    if (write) begin
                        if (count != FULL_COUNT)
                            count <= count + (ADDR_W + 1)'(1);
                        if (addr == LAST_ADDR) begin
                            if (mode_l) begin
                                addr    <= '0;
                                wrapped <= 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_log_ctrl.sv
// tb_bram_log_ctrl
//   Directed-vector bench for bram_log_ctrl with DEPTH=8 in a 16-word
//   address space. Inputs change 1 ns after the rising edge; outputs are
//   compared 1 ns later, well clear of the next edge.
module tb_bram_log_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;
    localparam int DEC_W  = 8;

    logic              clk;
    logic              rst;
    logic              run;
    logic              stop;
    logic              mode;
    logic [DEC_W-1:0]  decim;
    logic              in_valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;
    logic              wrapped;
    logic [ADDR_W:0]   count;

    int n_vec;
    int n_err;

    bram_log_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DEC_W  (DEC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .stop     (stop),
        .mode     (mode),
        .decim    (decim),
        .in_valid (in_valid),
        .write    (write),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // advance to 1 ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        run      = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        decim    = '0;
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        settle();

        // reset state
        check("rst_write",   int'(write),   0);
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_addr",    int'(addr),    0);
        check("rst_count",   int'(count),   0);
        check("rst_wrapped", int'(wrapped), 0);

        // stop alone in IDLE is ignored
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        settle();
        check("idle_stop_busy", int'(busy), 0);
        check("idle_stop_done", int'(done), 0);

        // one-shot, decim 0, continuous valid: addr 0..7 then DONE
        mode = 1'b0; decim = 8'd0; in_valid = 1'b1; run = 1'b1;
        cyc();
        run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("os_write", int'(write), 1);
            check("os_addr",  int'(addr),  i);
            check("os_busy",  int'(busy),  1);
            cyc();
        end
        settle();
        check("os_done",    int'(done),    1);
        check("os_busy_lo", int'(busy),    0);
        check("os_write_lo",int'(write),   0);
        check("os_count",   int'(count),   8);
        check("os_wrapped", int'(wrapped), 0);
        check("os_addr_end",int'(addr),    7);
        cyc();
        settle();
        check("os_addr_hold", int'(addr), 7);

        // one-shot, decim 2: writes on valid 1,4,7,..,22
        decim = 8'd2; run = 1'b1;
        cyc();
        run = 1'b0;
        check("d2_restart_count", int'(count), 0);
        for (int k = 0; k < 22; k++) begin
            settle();
            check("d2_write", int'(write), (k % 3 == 0) ? 1 : 0);
            check("d2_addr",  int'(addr),  (k + 2) / 3);
            cyc();
        end
        settle();
        check("d2_done",  int'(done),  1);
        check("d2_count", int'(count), 8);
        check("d2_addr_end", int'(addr), 7);

        // circular, decim 0: 12 samples, stop with the 13th
        mode = 1'b1; decim = 8'd0; run = 1'b1;
        cyc();
        run = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 12) stop = 1'b1;
            settle();
            check("circ_write",   int'(write),   1);
            check("circ_addr",    int'(addr),    k % 8);
            check("circ_wrapped", int'(wrapped), (k >= 8) ? 1 : 0);
            check("circ_count",   int'(count),   (k < 8) ? k : 8);
            cyc();
        end
        stop = 1'b0; in_valid = 1'b0;
        settle();
        check("circ_done",    int'(done),    1);
        check("circ_addr_end",int'(addr),    5);
        check("circ_wrap_end",int'(wrapped), 1);
        check("circ_count_end",int'(count),  8);

        // restart from DONE: one-shot, decim 1, toggling valid
        mode = 1'b0; decim = 8'd1; run = 1'b1;
        cyc();
        run = 1'b0;
        check("rs_addr",    int'(addr),    0);
        check("rs_count",   int'(count),   0);
        check("rs_wrapped", int'(wrapped), 0);
        check("rs_busy",    int'(busy),    1);
        for (int c = 0; c < 8; c++) begin
            in_valid = (c % 2 == 0);
            settle();
            check("tog_write", int'(write), (c % 4 == 0) ? 1 : 0);
            check("tog_addr",  int'(addr),  (c + 3) / 4);
            cyc();
        end
        // run during WRITE ignored, mode change ignored
        in_valid = 1'b1; run = 1'b1; mode = 1'b1;
        settle();
        check("wr_run_write", int'(write), 1);
        check("wr_run_addr",  int'(addr),  2);
        cyc();
        run = 1'b0; in_valid = 1'b0; stop = 1'b1;
        settle();
        check("wr_run_busy",  int'(busy),  1);
        check("wr_run_addr2", int'(addr),  3);
        check("wr_run_count", int'(count), 3);
        cyc();
        stop = 1'b0;
        settle();
        check("stop_done",    int'(done),    1);
        check("stop_addr",    int'(addr),    3);
        check("stop_count",   int'(count),   3);
        check("stop_wrapped", int'(wrapped), 0);

        // reset mid-capture at addr 3
        mode = 1'b0; decim = 8'd0; in_valid = 1'b1; run = 1'b1;
        cyc();
        run = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        settle();
        check("mid_addr",  int'(addr),  3);
        check("mid_write", int'(write), 1);
        cyc();
        rst = 1'b0;
        settle();
        check("mrst_write", int'(write), 0);
        check("mrst_addr",  int'(addr),  0);
        check("mrst_count", int'(count), 0);
        check("mrst_busy",  int'(busy),  0);
        check("mrst_done",  int'(done),  0);

        // run and stop together in IDLE start a capture
        run = 1'b1; stop = 1'b1;
        cyc();
        run = 1'b0; stop = 1'b0;
        settle();
        check("rs_both_busy",  int'(busy),  1);
        check("rs_both_write", int'(write), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
